// File: rtl/uart_param.sv
// Parameterised UART: oversampling receiver and transmitter sharing one
// clk-domain tick enable. Frame format is set by DATA_BITS, PARITY and STOP_BITS.
module uart_param #(
  parameter int CLOCK_RATE = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rx_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 rx_err_frame,
  output logic                 rx_err_parity,
  output logic                 tx,
  input  logic                 tx_en,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int DIV_RAW = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(OVERSAMPLE);
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] w);
    return (PARITY == 1) ? ~(^w) : ^w;
  endfunction

  logic [DW-1:0] tick_cnt;
  logic          tick;
  logic          rx_meta, rx_sync;

  assign tick = (tick_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      rx_meta  <= rx;
      rx_sync  <= rx_meta;
    end
  end

  // Receiver
  rx_state_t            rx_state, rx_state_nxt;
  logic [SW-1:0]        rx_scnt, rx_scnt_nxt;
  logic [3:0]           rx_bit, rx_bit_nxt;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_nxt, rx_data_nxt;
  logic                 rx_perr, rx_perr_nxt;
  logic                 rx_valid_nxt, rx_err_frame_nxt, rx_err_parity_nxt;
  logic                 rx_bit_end;

  assign rx_bit_end = tick && (rx_scnt == S_LAST);
  assign rx_busy    = (rx_state != RX_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state      <= RX_IDLE;
      rx_scnt       <= '0;
      rx_bit        <= '0;
      rx_shift      <= '0;
      rx_perr       <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_err_frame  <= 1'b0;
      rx_err_parity <= 1'b0;
    end else begin
      rx_state      <= rx_state_nxt;
      rx_scnt       <= rx_scnt_nxt;
      rx_bit        <= rx_bit_nxt;
      rx_shift      <= rx_shift_nxt;
      rx_perr       <= rx_perr_nxt;
      rx_data       <= rx_data_nxt;
      rx_valid      <= rx_valid_nxt;
      rx_err_frame  <= rx_err_frame_nxt;
      rx_err_parity <= rx_err_parity_nxt;
    end
  end

  // Parity errors are held pending so all results publish at the stop sample.
  always_comb begin
    rx_state_nxt      = rx_state;
    rx_scnt_nxt       = rx_scnt;
    rx_bit_nxt        = rx_bit;
    rx_shift_nxt      = rx_shift;
    rx_perr_nxt       = rx_perr;
    rx_data_nxt       = rx_data;
    rx_valid_nxt      = 1'b0;
    rx_err_frame_nxt  = rx_err_frame;
    rx_err_parity_nxt = rx_err_parity;
    if (rx_state != RX_IDLE && !rx_en) begin
      rx_state_nxt = RX_IDLE;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_en && !rx_sync) begin
            rx_state_nxt = RX_START;
            rx_scnt_nxt  = '0;
            rx_bit_nxt   = '0;
            rx_perr_nxt  = 1'b0;
          end
        end
        RX_START: begin
          if (tick) begin
            if (rx_scnt == S_MID) begin
              rx_scnt_nxt  = '0;
              rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
            end else begin
              rx_scnt_nxt = rx_scnt + 1'b1;
            end
          end
        end
        RX_DATA: begin
          if (rx_bit_end) begin
            rx_scnt_nxt  = '0;
            rx_shift_nxt = {rx_sync, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == BIT_LAST) begin
              rx_state_nxt = (PARITY == 0) ? RX_STOP : RX_PARITY;
            end else begin
              rx_bit_nxt = rx_bit + 1'b1;
            end
          end else if (tick) begin
            rx_scnt_nxt = rx_scnt + 1'b1;
          end
        end
        RX_PARITY: begin
          if (rx_bit_end) begin
            rx_scnt_nxt  = '0;
            rx_perr_nxt  = (rx_sync != calc_parity(rx_shift));
            rx_state_nxt = RX_STOP;
          end else if (tick) begin
            rx_scnt_nxt = rx_scnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_bit_end) begin
            rx_scnt_nxt       = '0;
            rx_valid_nxt      = 1'b1;
            rx_data_nxt       = rx_shift;
            rx_err_frame_nxt  = !rx_sync;
            rx_err_parity_nxt = rx_perr;
            rx_state_nxt      = RX_IDLE;
          end else if (tick) begin
            rx_scnt_nxt = rx_scnt + 1'b1;
          end
        end
        default: rx_state_nxt = RX_IDLE;
      endcase
    end
  end

  // Transmitter
  tx_state_t            tx_state, tx_state_nxt;
  logic [SW-1:0]        tx_scnt, tx_scnt_nxt;
  logic [3:0]           tx_bit, tx_bit_nxt;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_nxt, tx_word, tx_word_nxt;
  logic                 tx_line_nxt, tx_done_nxt;
  logic                 tx_bit_end;

  assign tx_bit_end = tick && (tx_scnt == S_LAST);
  assign tx_busy    = (tx_state != TX_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_scnt  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_word  <= '0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_scnt  <= tx_scnt_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_shift <= tx_shift_nxt;
      tx_word  <= tx_word_nxt;
      tx       <= tx_line_nxt;
      tx_done  <= tx_done_nxt;
    end
  end

  // The line level is derived from the next state so tx changes with the state flop.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_scnt_nxt  = tx_scnt;
    tx_bit_nxt   = tx_bit;
    tx_shift_nxt = tx_shift;
    tx_word_nxt  = tx_word;
    tx_done_nxt  = 1'b0;
    tx_line_nxt  = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        if (tx_en && tx_start) begin
          tx_state_nxt = TX_START;
          tx_word_nxt  = tx_data;
          tx_shift_nxt = tx_data;
          tx_scnt_nxt  = '0;
          tx_bit_nxt   = '0;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_scnt_nxt  = '0;
          tx_state_nxt = TX_DATA;
        end else if (tick) begin
          tx_scnt_nxt = tx_scnt + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_scnt_nxt = '0;
          if (tx_bit == BIT_LAST) begin
            tx_bit_nxt   = '0;
            tx_state_nxt = (PARITY == 0) ? TX_STOP : TX_PARITY;
          end else begin
            tx_bit_nxt   = tx_bit + 1'b1;
            tx_shift_nxt = tx_shift >> 1;
          end
        end else if (tick) begin
          tx_scnt_nxt = tx_scnt + 1'b1;
        end
      end
      TX_PARITY: begin
        if (tx_bit_end) begin
          tx_scnt_nxt  = '0;
          tx_bit_nxt   = '0;
          tx_state_nxt = TX_STOP;
        end else if (tick) begin
          tx_scnt_nxt = tx_scnt + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          tx_scnt_nxt = '0;
          if (tx_bit == STOP_LAST) begin
            tx_state_nxt = TX_IDLE;
            tx_done_nxt  = 1'b1;
          end else begin
            tx_bit_nxt = tx_bit + 1'b1;
          end
        end else if (tick) begin
          tx_scnt_nxt = tx_scnt + 1'b1;
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
    case (tx_state_nxt)
      TX_START:  tx_line_nxt = 1'b0;
      TX_DATA:   tx_line_nxt = tx_shift_nxt[0];
      TX_PARITY: tx_line_nxt = calc_parity(tx_word_nxt);
      default:   tx_line_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_param.sv
// Bench for uart_param: an 8N1 instance (a) and an 8E1 instance (b, optionally
// looped tx->rx); expected rx words and tx bits go through scoreboard queues.
`timescale 1ns/1ps
module tb_uart_param;

  localparam int CR = 1600000;
  localparam int BR = 10000;
  localparam int OS = 16;

  typedef struct {
    logic [7:0] data;
    logic       fe;
    logic       pe;
  } rx_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       rx_a_drv = 1'b1, rx_en_a = 1'b1, tx_en_a = 1'b1, tx_start_a = 1'b0;
  logic [7:0] tx_data_a = 8'h00;
  logic [7:0] rx_data_a;
  logic       rx_valid_a, rx_busy_a, fe_a, pe_a, tx_a, tx_busy_a, tx_done_a;

  logic       rx_b_drv = 1'b1, loop_b = 1'b0, rx_en_b = 1'b1, tx_en_b = 1'b1, tx_start_b = 1'b0;
  logic [7:0] tx_data_b = 8'h00;
  logic [7:0] rx_data_b;
  logic       rx_b, rx_valid_b, rx_busy_b, fe_b, pe_b, tx_b, tx_busy_b, tx_done_b;

  int n_checks = 0;
  int n_pass   = 0;
  int done_a   = 0;

  rx_exp_t exp_a[$];
  rx_exp_t exp_b[$];
  logic    tx_exp[$];
  rx_exp_t ea, eb;

  assign rx_b = loop_b ? tx_b : rx_b_drv;

  always #5 clk = ~clk;

  uart_param #(.CLOCK_RATE(CR), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0),
               .STOP_BITS(1), .OVERSAMPLE(OS)) dut_a (
    .clk(clk), .rst(rst), .rx(rx_a_drv), .rx_en(rx_en_a), .rx_data(rx_data_a),
    .rx_valid(rx_valid_a), .rx_busy(rx_busy_a), .rx_err_frame(fe_a),
    .rx_err_parity(pe_a), .tx(tx_a), .tx_en(tx_en_a), .tx_start(tx_start_a),
    .tx_data(tx_data_a), .tx_busy(tx_busy_a), .tx_done(tx_done_a)
  );

  uart_param #(.CLOCK_RATE(CR), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(2),
               .STOP_BITS(1), .OVERSAMPLE(OS)) dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .rx_en(rx_en_b), .rx_data(rx_data_b),
    .rx_valid(rx_valid_b), .rx_busy(rx_busy_b), .rx_err_frame(fe_b),
    .rx_err_parity(pe_b), .tx(tx_b), .tx_en(tx_en_b), .tx_start(tx_start_b),
    .tx_data(tx_data_b), .tx_busy(tx_busy_b), .tx_done(tx_done_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic pushExp(input bit sel, input logic [7:0] d, input logic fe, input logic pe);
    rx_exp_t e;
    e.data = d;
    e.fe   = fe;
    e.pe   = pe;
    if (sel) exp_b.push_back(e);
    else exp_a.push_back(e);
  endtask

  task automatic setLine(input bit sel, input logic v);
    if (sel) rx_b_drv = v;
    else rx_a_drv = v;
  endtask

  // Bit-bang one frame onto an rx line, 160 clks per bit, then idle high.
  task automatic applyStimulus(input bit sel, input logic [7:0] data, input bit use_par,
                               input logic par_bit, input logic stop_bit, input int stop_len);
    setLine(sel, 1'b0);
    repeat (160) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      setLine(sel, data[i]);
      repeat (160) @(negedge clk);
    end
    if (use_par) begin
      setLine(sel, par_bit);
      repeat (160) @(negedge clk);
    end
    setLine(sel, stop_bit);
    repeat (stop_len) @(negedge clk);
    setLine(sel, 1'b1);
    repeat (320) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (tx_done_a) done_a++;
    if (rx_valid_a) begin
      checkOutput("rx_a_expected_pending", exp_a.size() > 0, 1);
      if (exp_a.size() > 0) begin
        ea = exp_a.pop_front();
        checkOutput("rx_a_data", rx_data_a, ea.data);
        checkOutput("rx_a_err_frame", fe_a, ea.fe);
        checkOutput("rx_a_err_parity", pe_a, ea.pe);
      end
    end
    if (rx_valid_b) begin
      checkOutput("rx_b_expected_pending", exp_b.size() > 0, 1);
      if (exp_b.size() > 0) begin
        eb = exp_b.pop_front();
        checkOutput("rx_b_data", rx_data_b, eb.data);
        checkOutput("rx_b_err_frame", fe_b, eb.fe);
        checkOutput("rx_b_err_parity", pe_b, eb.pe);
      end
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit   found;
    int   lat;
    int   waitc;
    int   saved;
    logic [7:0] word;

    repeat (5) @(negedge clk);
    checkOutput("rst_tx_a", tx_a, 1);
    checkOutput("rst_tx_busy_a", tx_busy_a, 0);
    checkOutput("rst_tx_done_a", tx_done_a, 0);
    checkOutput("rst_rx_busy_a", rx_busy_a, 0);
    checkOutput("rst_rx_valid_a", rx_valid_a, 0);
    checkOutput("rst_rx_data_a", rx_data_a, 0);
    checkOutput("rst_err_a", {fe_a, pe_a}, 0);
    checkOutput("rst_tx_b", tx_b, 1);
    checkOutput("rst_rx_data_b", rx_data_b, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    tx_en_a = 1'b0;
    tx_data_a = 8'hFF;
    tx_start_a = 1'b1;
    @(negedge clk);
    tx_start_a = 1'b0;
    checkOutput("tx_start_ignored_when_disabled", tx_busy_a, 0);
    checkOutput("tx_line_idle_when_disabled", tx_a, 1);
    tx_en_a = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 frame 0xA5
    word = 8'hA5;
    tx_exp.push_back(1'b0);
    for (int i = 0; i < 8; i++) tx_exp.push_back(word[i]);
    tx_exp.push_back(1'b1);
    tx_data_a = word;
    tx_start_a = 1'b1;
    @(negedge clk);
    tx_start_a = 1'b0;
    checkOutput("tx_busy_set", tx_busy_a, 1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (tx_a == 1'b0) found = 1;
      else @(negedge clk);
    end
    checkOutput("tx_start_edge_seen", found, 1);
    for (int k = 0; k < 10; k++) begin
      waitc = (k == 0) ? 80 : ((k == 4) ? 159 : 160);
      repeat (waitc) @(negedge clk);
      checkOutput("tx_bit", tx_a, tx_exp.pop_front());
      if (k == 3) begin
        tx_data_a = 8'hFF;
        tx_start_a = 1'b1;
        @(negedge clk);
        tx_start_a = 1'b0;
      end
    end
    found = 0;
    lat = 1520;
    for (int j = 0; j < 200 && !found; j++) begin
      @(negedge clk);
      lat++;
      if (tx_done_a) found = 1;
    end
    checkOutput("tx_done_seen", found, 1);
    checkOutput("tx_done_latency_in_window", (lat >= 1590 && lat <= 1601), 1);
    checkOutput("tx_busy_clear_at_done", tx_busy_a, 0);

    // Start in the tx_done clk, then reset during data bit 3 of that frame
    tx_data_a = 8'h5A;
    tx_start_a = 1'b1;
    @(negedge clk);
    tx_start_a = 1'b0;
    checkOutput("tx_done_one_clk", tx_done_a, 0);
    checkOutput("tx_start_in_done_clk_accepted", tx_busy_a, 1);
    checkOutput("tx_5a_start_bit", tx_a, 0);
    repeat (720) @(negedge clk);
    checkOutput("tx_5a_bit3", tx_a, 1);
    saved = done_a;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("tx_line_after_rst", tx_a, 1);
    checkOutput("tx_busy_after_rst", tx_busy_a, 0);
    repeat (2000) @(negedge clk);
    checkOutput("tx_no_done_after_rst", done_a - saved, 0);
    checkOutput("tx_idle_after_rst", tx_a, 1);

    // 8N1 receiver cases
    pushExp(0, 8'hC3, 1'b0, 1'b0);
    applyStimulus(0, 8'hC3, 0, 1'b0, 1'b1, 160);
    pushExp(0, 8'h55, 1'b1, 1'b0);
    applyStimulus(0, 8'h55, 0, 1'b0, 1'b0, 100);
    checkOutput("rx_frame_err_hold", fe_a, 1);
    checkOutput("rx_data_hold", rx_data_a, 8'h55);

    setLine(0, 1'b0);
    repeat (20) @(negedge clk);
    checkOutput("rx_glitch_busy", rx_busy_a, 1);
    repeat (20) @(negedge clk);
    setLine(0, 1'b1);
    repeat (50) @(negedge clk);
    checkOutput("rx_glitch_busy_clear", rx_busy_a, 0);
    repeat (300) @(negedge clk);

    fork
      applyStimulus(0, 8'h96, 0, 1'b0, 1'b1, 160);
      begin
        repeat (800) @(negedge clk);
        rx_en_a = 1'b0;
        @(negedge clk);
        checkOutput("rx_abort_busy_clear", rx_busy_a, 0);
      end
    join
    rx_en_a = 1'b1;
    checkOutput("rx_abort_data_kept", rx_data_a, 8'h55);

    // Even-parity instance: flipped parity bit, then tx looped to rx
    pushExp(1, 8'h01, 1'b0, 1'b1);
    applyStimulus(1, 8'h01, 1, 1'b0, 1'b1, 160);
    checkOutput("rx_parity_err_hold", pe_b, 1);

    loop_b = 1'b1;
    pushExp(1, 8'h3C, 1'b0, 1'b0);
    tx_data_b = 8'h3C;
    tx_start_b = 1'b1;
    @(negedge clk);
    tx_start_b = 1'b0;
    found = 0;
    for (int j = 0; j < 2400 && !found; j++) begin
      @(negedge clk);
      if (tx_done_b) found = 1;
    end
    checkOutput("loop_tx_done_seen", found, 1);
    repeat (100) @(negedge clk);
    loop_b = 1'b0;
    checkOutput("loop_rx_err_parity", pe_b, 0);

    checkOutput("rx_a_all_frames_seen", exp_a.size(), 0);
    checkOutput("rx_b_all_frames_seen", exp_b.size(), 0);
    checkOutput("tx_bits_drained", tx_exp.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_param.md
UART_PARAM -- requirements
Module: uart_param

Interface
REQ-001 Parameter CLOCK_RATE, default 100000000, input clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, line bit rate in bits per second.
REQ-003 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-004 Parameter PARITY, default 0; 0 = none, 1 = odd, 2 = even.
REQ-005 Parameter STOP_BITS, default 1; legal values 1 or 2.
REQ-006 Parameter OVERSAMPLE, default 16, sample ticks per bit; must be even and at least 8.
REQ-007 clk  in  1  sole clock; every flop is clocked on its rising edge.
REQ-008 rst  in  1  synchronous reset, active-high.
REQ-009 rx  in  1  asynchronous serial input; idles high.
REQ-010 rx_en  in  1  receiver enable.
REQ-011 rx_data  out  DATA_BITS  last received word.
REQ-012 rx_valid  out  1  one-clk pulse: frame complete.
REQ-013 rx_busy  out  1  receiver is inside a frame.
REQ-014 rx_err_frame  out  1  stop-bit error of the last frame.
REQ-015 rx_err_parity  out  1  parity error of the last frame.
REQ-016 tx  out  1  serial output; idles high.
REQ-017 tx_en  in  1  transmitter enable.
REQ-018 tx_start  in  1  frame request.
REQ-019 tx_data  in  DATA_BITS  word to send.
REQ-020 tx_busy  out  1  transmitter is inside a frame.
REQ-021 tx_done  out  1  one-clk pulse: frame sent.

Function
REQ-022 Tick generator: a clk-domain enable pulse fires every DIV = max(1, floor(CLOCK_RATE/(BAUD_RATE*OVERSAMPLE))) clks; no derived clocks.
REQ-023 rx passes through a 2-flop synchronizer before use.
REQ-024 RX FSM states: IDLE, START, DATA, PARITY, STOP; the PARITY state is skipped when PARITY=0.
REQ-025 In IDLE with rx_en=1, a synchronized low on rx moves the FSM to START and asserts rx_busy.
REQ-026 START samples rx at tick OVERSAMPLE/2-1; rx high there means a glitch, so return to IDLE with no rx_valid.
REQ-027 DATA bits are sampled every OVERSAMPLE ticks after the start midpoint, LSB first.
REQ-028 PARITY compares the sampled bit with the computed parity; a mismatch sets rx_err_parity.
REQ-029 STOP checks only the first stop bit; rx low there sets rx_err_frame.
REQ-030 At the stop sample: rx_valid pulses for one clk, rx_data and both error flags update together, the FSM returns to IDLE, and rx_busy clears.
REQ-031 rx_valid also pulses on an errored frame.
REQ-032 rx_data and the error flags hold their values until the next rx_valid.
REQ-033 Deasserting rx_en mid-frame aborts to IDLE on the next clk, with no rx_valid.
REQ-034 TX FSM states: IDLE, START, DATA, PARITY, STOP; each bit lasts OVERSAMPLE ticks; tx_data is sent LSB first.
REQ-035 In IDLE with tx_en=1, tx_start=1 latches tx_data, sets tx_busy on the next clk, and drives tx low for START.
REQ-036 tx_start while busy or while tx_en=0 is ignored; the latched word is not disturbed.
REQ-037 STOP drives tx high for STOP_BITS bit periods.
REQ-038 tx_done pulses for one clk when STOP ends; tx_busy clears in the same clk.
REQ-039 tx_start asserted in the tx_done clk is accepted.
REQ-040 Deasserting tx_en mid-frame does not truncate the frame; the transmitter finishes the frame and then stays idle.
REQ-041 Parity is XOR of the data bits for even parity and its inverse for odd parity.

Reset
REQ-042 While rst=1: tx=1; rx_data, rx_valid, rx_busy, rx_err_frame, rx_err_parity, tx_busy and tx_done are all 0; both FSMs are in IDLE; the tick counter and synchronizer are cleared, with the synchronizer set to 1.
REQ-043 rst asserted mid-frame takes effect on the next clk edge; no rx_valid or tx_done is produced for the aborted frame.

Verification
All scenarios use CLOCK_RATE=1600000, BAUD_RATE=10000, OVERSAMPLE=16, giving DIV=10 and 160 clks per bit.
REQ-044 8N1, tx_start with tx_data=0xA5 -> tx shows start 0, then bits 1,0,1,0,0,1,0,1, then stop 1, each 160 clks; tx_done pulses about 1600 clks after the start edge.
REQ-045 Even parity, tx looped to rx, tx_data=0x3C -> rx_valid pulse with rx_data=0x3C and both error flags 0.
REQ-046 40-clk low glitch on idle rx -> no rx_valid; rx_busy returns to 0 within 90 clks.
REQ-047 Frame 0x55 with the stop bit forced low -> rx_valid with rx_data=0x55 and rx_err_frame=1.
REQ-048 Even parity, frame 0x01 with the parity bit flipped to 0 -> rx_valid with rx_err_parity=1.
REQ-049 rst pulsed for 1 clk during data bit 3 of a TX frame -> tx=1 and tx_busy=0 on the next clk; no tx_done pulse.
